// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes, FSM states
// and the pipeline/divider handshake constants.
package hilo_muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL_WAIT,
    MD_DIV_WAIT,
    MD_DONE
  } md_state_e;

  localparam logic STOP             = 1'b1;
  localparam logic NO_STOP          = 1'b0;
  localparam logic DIV_START        = 1'b1;
  localparam logic DIV_STOP         = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;

  function automatic logic is_signed_op(input logic [2:0] code);
    return (code == MD_MULT) || (code == MD_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_hilo_reg.sv
// Architectural HI/LO register pair; each half has its own write enable.
module hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we,
  input  logic [31:0] hi_wdata,
  input  logic        lo_we,
  input  logic [31:0] lo_wdata,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_we ? hi_wdata : hi_q;
    lo_d = lo_we ? lo_wdata : lo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage sequencer for the multiplier and divider; owns HI/LO and raises the
// EX stall while an operation is in flight.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready
);

  localparam int unsigned CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic             sgn_q, sgn_d;

  logic             hi_we, lo_we;
  logic [31:0]      hi_wdata, lo_wdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sgn_d       = sgn_q;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    hi_wdata    = '0;
    lo_wdata    = '0;
    stallreq    = NO_STOP;
    div_start   = DIV_STOP;
    div_annul   = 1'b0;
    mul_signed  = 1'b0;
    mul_ina     = '0;
    mul_inb     = '0;
    div_signed  = 1'b0;
    div_opdata1 = '0;
    div_opdata2 = '0;

    unique case (state_q)
      MD_IDLE: begin
        if (op_valid) begin
          case (op)
            MD_MTHI: begin
              hi_we    = 1'b1;
              hi_wdata = src_a;
            end
            MD_MTLO: begin
              lo_we    = 1'b1;
              lo_wdata = src_a;
            end
            MD_MULT, MD_MULTU: begin
              opa_d    = src_a;
              opb_d    = src_b;
              sgn_d    = is_signed_op(op);
              cnt_d    = CNT_INIT;
              state_d  = MD_MUL_WAIT;
              stallreq = STOP;
            end
            MD_DIV, MD_DIVU: begin
              // Divide-by-zero is architecturally undefined: leave HI/LO alone.
              if (src_b != '0) begin
                opa_d    = src_a;
                opb_d    = src_b;
                sgn_d    = is_signed_op(op);
                state_d  = MD_DIV_WAIT;
                stallreq = STOP;
              end
            end
            default: ;
          endcase
        end
      end
      MD_MUL_WAIT: begin
        mul_signed = sgn_q;
        mul_ina    = opa_q;
        mul_inb    = opb_q;
        stallreq   = STOP;
        if (cnt_q == '0) begin
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          hi_wdata = mul_result[63:32];
          lo_wdata = mul_result[31:0];
          state_d  = MD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DIV_WAIT: begin
        div_signed  = sgn_q;
        div_opdata1 = opa_q;
        div_opdata2 = opb_q;
        if (div_ready == DIV_RESULT_READY) begin
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          hi_wdata = div_result[63:32];
          lo_wdata = div_result[31:0];
          state_d  = MD_IDLE;
        end else begin
          div_start = DIV_START;
          stallreq  = STOP;
        end
      end
      MD_DONE: begin
        // The committed instruction is still in EX this cycle; do not re-accept it.
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    // rst resets the divider directly, so only a flush needs to annul it.
    if (flush || rst) begin
      div_annul = flush && !rst && (state_q == MD_DIV_WAIT);
      state_d   = MD_IDLE;
      cnt_d     = '0;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      stallreq  = NO_STOP;
      div_start = DIV_STOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
    end
  end

  hilo_reg u_hilo_reg (
    .clk      (clk),
    .rst      (rst),
    .hi_we    (hi_we),
    .hi_wdata (hi_wdata),
    .lo_we    (lo_we),
    .lo_wdata (lo_wdata),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata)
  );

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: multiplier/divider models, HI/LO commit scoreboard
// and directed handshake checks.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam int unsigned MUL_LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst, flush, op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq;
  logic [31:0] hi_rdata, lo_rdata;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul, div_ready;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb[$];
  logic        mon_en = 1'b0;
  logic [63:0] mon_prev;
  logic [63:0] mon_exp;
  int unsigned dcnt;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.MUL_LATENCY(MUL_LATENCY)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .op_valid    (op_valid),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .stallreq    (stallreq),
    .hi_rdata    (hi_rdata),
    .lo_rdata    (lo_rdata),
    .mul_signed  (mul_signed),
    .mul_ina     (mul_ina),
    .mul_inb     (mul_inb),
    .mul_result  (mul_result),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .div_opdata1 (div_opdata1),
    .div_opdata2 (div_opdata2),
    .div_annul   (div_annul),
    .div_result  (div_result),
    .div_ready   (div_ready)
  );

  // One-stage multiplier: result valid one cycle after operands are presented.
  always @(posedge clk)
    mul_result <= mul_signed ? ({{32{mul_ina[31]}}, mul_ina} * {{32{mul_inb[31]}}, mul_inb})
                             : ({32'd0, mul_ina} * {32'd0, mul_inb});

  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Iterative divider: ready after 33 cycles of div_start.
  always @(posedge clk) begin
    if (rst || div_annul) begin
      dcnt       <= 0;
      div_ready  <= 1'b0;
      div_result <= '0;
    end else if (div_start && !div_ready) begin
      if (dcnt == 32) begin
        div_ready  <= 1'b1;
        dcnt       <= 0;
        div_result <= div_model(div_signed, div_opdata1, div_opdata2);
      end else begin
        dcnt <= dcnt + 1;
      end
    end else begin
      div_ready <= 1'b0;
      dcnt      <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every visible HI/LO change must match the oldest pending commit.
  always @(negedge clk) begin
    if (mon_en && ({hi_rdata, lo_rdata} !== mon_prev)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL hilo_unexpected: got %h expected unchanged %h", {hi_rdata, lo_rdata}, mon_prev);
      end else begin
        mon_exp = sb.pop_front();
        chk("hilo_commit", {hi_rdata, lo_rdata}, mon_exp);
      end
      mon_prev = {hi_rdata, lo_rdata};
    end
  end

  task automatic do_mul(input string nm, input md_op_e o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int   n = 0;
    logic bad = 1'b0;
    logic exp_sgn = (o == MD_MULT);
    sb.push_back(exp);
    @(negedge clk);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stallreq) break;
      n++;
      if (n > 1 && (mul_signed !== exp_sgn || mul_ina !== a || mul_inb !== b)) bad = 1'b1;
      @(negedge clk);
      src_a = ~a;
      src_b = b ^ 32'h5a5a5a5a;
    end
    chk({nm, "_stall_cycles"}, 64'(n), 64'(1 + MUL_LATENCY));
    chk({nm, "_mul_bus"}, 64'(bad), 64'd0);
    chk({nm, "_done_divstart"}, 64'(div_start), 64'd0);
  endtask

  task automatic do_div(input string nm, input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input logic [63:0] exp, input logic push);
    int   n = 0;
    logic bad = 1'b0;
    logic done = 1'b0;
    if (push) sb.push_back(exp);
    @(negedge clk);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    chk({nm, "_accept"}, {stallreq, div_start}, 64'b10);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      src_a = 32'hdeadbeef;
      src_b = 32'h1;
      n++;
      if (n == flush_at) begin
        flush = 1'b1;
        #1;
        chk({nm, "_annul"}, {div_annul, stallreq, div_start}, 64'b100);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        chk({nm, "_post_flush"}, {div_annul, stallreq, div_start}, 64'b000);
        done = 1'b1;
      end else begin
        #1;
        if (div_ready) begin
          chk({nm, "_ready_cycle"}, {stallreq, div_start}, 64'b00);
          done = 1'b1;
        end else if (stallreq !== 1'b1 || div_start !== 1'b1 || div_annul !== 1'b0 ||
                     div_opdata1 !== a || div_opdata2 !== b || div_signed !== (o == MD_DIV)) begin
          bad = 1'b1;
        end
      end
    end
    chk({nm, "_wait_ok"}, {bad, done}, 64'b01);
    if (flush_at == 0) chk({nm, "_wait_len"}, 64'(n), 64'd34);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_hilo", {hi_rdata, lo_rdata}, 64'd0);
    chk("rst_ctrl", {stallreq, div_start, div_annul, mul_signed, div_signed}, 64'd0);
    chk("rst_mulbus", {mul_ina, mul_inb}, 64'd0);
    chk("rst_divbus", {div_opdata1, div_opdata2}, 64'd0);
    mon_prev = 64'd0;
    mon_en   = 1'b1;

    do_mul("mult", MD_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    @(negedge clk); op_valid = 1'b0;
    do_mul("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE);
    @(negedge clk); op_valid = 1'b0;
    do_div("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 0, 64'hFFFFFFFF_FFFFFFFD, 1'b1);
    @(negedge clk); op_valid = 1'b0;

    sb.push_back(64'h00001234_FFFFFFFD);
    @(negedge clk); op_valid = 1'b1; op = MD_MTHI; src_a = 32'h1234; #1;
    chk("mthi_stall", 64'(stallreq), 64'd0);
    sb.push_back(64'h00001234_00005678);
    @(negedge clk); op = MD_MTLO; src_a = 32'h5678; #1;
    chk("mtlo_stall", 64'(stallreq), 64'd0);
    @(negedge clk); op = MD_DIVU; src_a = 32'd7; src_b = 32'd0; #1;
    chk("divu0_stall", 64'(stallreq), 64'd0);
    seen = div_start;
    @(negedge clk); op_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (div_start || stallreq) seen = 1'b1;
      @(negedge clk);
    end
    chk("divu0_quiet", 64'(seen), 64'd0);
    chk("divu0_hilo", {hi_rdata, lo_rdata}, 64'h00001234_00005678);

    @(negedge clk); op_valid = 1'b1; op = MD_MTHI; src_a = 32'hDEAD0000; flush = 1'b1; #1;
    chk("flush_mthi_stall", 64'(stallreq), 64'd0);
    @(negedge clk); op_valid = 1'b0; flush = 1'b0; #1;
    chk("flush_mthi_hilo", {hi_rdata, lo_rdata}, 64'h00001234_00005678);

    do_div("div_flush", MD_DIV, 32'd100, 32'd7, 10, 64'd0, 1'b0);
    chk("div_flush_hilo", {hi_rdata, lo_rdata}, 64'h00001234_00005678);
    do_mul("mult34", MD_MULT, 32'd3, 32'd4, 64'h00000000_0000000C);
    @(negedge clk); op_valid = 1'b0;

    sb.push_back(64'd0);
    @(negedge clk); op_valid = 1'b1; op = MD_MULTU; src_a = 32'h10000; src_b = 32'h10000; #1;
    chk("rstmul_accept", 64'(stallreq), 64'd1);
    @(negedge clk); rst = 1'b1; op_valid = 1'b0; #1;
    chk("rstmul_rst_cycle", {stallreq, div_annul}, 64'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rstmul_ctrl", {stallreq, div_start, div_annul, mul_signed, div_signed}, 64'd0);
    chk("rstmul_mulbus", {mul_ina, mul_inb}, 64'd0);
    chk("rstmul_divbus", {div_opdata1, div_opdata2}, 64'd0);
    chk("rstmul_hilo", {hi_rdata, lo_rdata}, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("rstmul_no_late_commit", {hi_rdata, lo_rdata}, 64'd0);

    do_mul("b2b_mult", MD_MULT, 32'd6, 32'd7, 64'd42);
    do_div("b2b_div", MD_DIV, 32'd42, 32'd5, 0, {32'd2, 32'd8}, 1'b1);
    @(negedge clk); op_valid = 1'b0;

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Sequencer for the EX-stage multiply/divide resources and owner of the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and drives the pipelined multiplier and the iterative divider (start/ready/annul handshake).
- Raises the EX stall request while an operation is in flight, then commits the 64-bit result to HI/LO.
- Sits beside the ALU in EX; its stallreq feeds the pipeline stall controller.

Parameters:
- MUL_LATENCY, 2, cycles from stable multiplier operands to valid mul_result (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  abort in-flight operation; no HI/LO write.
- op_valid  in  1  EX holds a HI/LO-class instruction this cycle.
- op  in  3  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- src_a  in  32  rs operand.
- src_b  in  32  rt operand.
- stallreq  out  1  hold the pipeline at EX (combinational).
- hi_rdata  out  32  current HI register (registered).
- lo_rdata  out  32  current LO register (registered).
- mul_signed  out  1  to multiplier.
- mul_ina  out  32  to multiplier.
- mul_inb  out  32  to multiplier.
- mul_result  in  64  from multiplier, {hi,lo}.
- div_start  out  1  to divider.
- div_signed  out  1  to divider.
- div_opdata1  out  32  dividend.
- div_opdata2  out  32  divisor.
- div_annul  out  1  abort divider.
- div_result  in  64  {remainder, quotient}.
- div_ready  in  1  divider result valid.

Behaviour:
- Reset:
  - state IDLE; HI, LO, operand latches and counter = 0.
  - All outputs 0: stallreq, div_start, div_annul, mul_signed, div_signed, operand buses, hi_rdata, lo_rdata.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE, op_valid=0: nothing happens; stallreq=0.
- IDLE, op_valid=1, MTHI/MTLO: HI (or LO) <= src_a at the clock edge; stallreq=0; state stays IDLE.
- IDLE, op_valid=1, MULT/MULTU:
  - Latch src_a, src_b and signedness (MULT=signed).
  - Counter <= MUL_LATENCY-1; next state MUL_WAIT; stallreq=1 combinationally in the accept cycle.
- IDLE, op_valid=1, DIV/DIVU with src_b != 0:
  - Latch operands and signedness; next state DIV_WAIT; stallreq=1 in the accept cycle.
- IDLE, op_valid=1, DIV/DIVU with src_b == 0: no stall, divider not started, HI/LO unchanged, stay IDLE.
- MUL_WAIT:
  - mul_ina/mul_inb/mul_signed driven from the latches; stallreq=1.
  - Counter decrements each cycle.
  - When counter==0: HI <= mul_result[63:32], LO <= mul_result[31:0]; next state DONE.
  - Total stall = 1 + MUL_LATENCY cycles.
- DIV_WAIT:
  - div_opdata1/2 and div_signed driven from the latches.
  - div_start=1 while div_ready=0; stallreq=1 while div_ready=0.
  - Cycle with div_ready=1: div_start=0, stallreq=0; HI <= div_result[63:32], LO <= div_result[31:0]; next state IDLE.
- DONE:
  - stallreq=0, so the instruction leaves EX this cycle.
  - op_valid is ignored, which prevents re-issuing the same instruction; next state IDLE.
- Operand latches are the only source for the mul/div buses. Changes on src_a/src_b during a wait have no effect.
- Outside their active states, operand buses, div_start and div_signed are 0.
- flush (priority over all but rst):
  - Next state IDLE; counter cleared; no HI/LO write in that cycle.
  - stallreq=0 that cycle.
  - If the state is DIV_WAIT: div_annul=1 for exactly that cycle and div_start=0.
  - flush with op_valid in IDLE: the op is discarded; an MTHI/MTLO write is also suppressed.
- rst mid-operation: identical to a flush, plus HI/LO cleared. div_annul is not asserted because the divider is reset by the same rst.
- hi_rdata/lo_rdata reflect the registers. A commit is visible the cycle after its commit edge, so a following MFHI in EX sees the new value.

Decomposition:
- defines.vh:
  - MD_* op encodings.
  - MD_IDLE/MD_MUL_WAIT/MD_DIV_WAIT/MD_DONE state encodings.
  - Reuse of the existing Stop/NoStop, DivStart/DivStop and DivResultReady/NotReady constants.
- One natural sub-module: hilo_reg (HI/LO pair with independent write enables, synchronous reset).
- FSM and handshakes stay in the top.

Test Plan:
- MULT src_a=0xFFFFFFFD, src_b=5 -> stallreq high 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; DONE cycle stallreq=0.
- MULTU 0xFFFFFFFF x 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE; mul_signed=0 throughout.
- DIV 0xFFFFFFF9 / 2 with a model divider (ready after 33 cycles):
  - div_start high until ready, stallreq low on the ready cycle.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 after MTHI 0x1234 and MTLO 0x5678 -> no stall, div_start never rises, HI=0x1234, LO=0x5678.
- DIV issued, flush asserted at the 10th wait cycle:
  - div_annul=1 for one cycle, stallreq=0, state IDLE, HI/LO unchanged.
  - A following MULT 3x4 gives LO=12, HI=0.
- rst asserted during MUL_WAIT -> next cycle all outputs 0, HI=LO=0.
- Back-to-back MULT then DIV: DONE ignores the held op_valid; the DIV starts only after DONE.
